mod_buffer_reader: RTL
======================

MOD_BUFFER_READER -- requirements
Module: mod_buffer_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, meaning I/Q sample width (signed).
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, meaning buffer address width.
REQ-003 SHALL have parameter MAX_SYMB, default 1200, meaning the maximum number of symbols per bank.
REQ-004 SHALL have port CLK_Mod  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port RST_Mod  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Done_In  input  1  one-cycle pulse: the writer has completed the current fill bank.
REQ-007 SHALL have port Last_addr_In  input  ADDR_WIDTH  symbol count of the completed bank; sampled only when Done_In=1.
REQ-008 SHALL have port Rd_en  output  1  buffer read strobe.
REQ-009 SHALL have port Rd_bank  output  1  bank being read (0/1).
REQ-010 SHALL have port Rd_addr  output  ADDR_WIDTH  read address.
REQ-011 SHALL have ports Rd_data_I and Rd_data_Q  input  DATA_WIDTH each  buffer data, valid exactly 1 cycle after Rd_en.
REQ-012 SHALL have ports Out_I and Out_Q  output  DATA_WIDTH each  streamed symbol.
REQ-013 SHALL have port Out_Valid  output  1; port Out_Ready  input  1; transfer occurs when both are 1.
REQ-014 SHALL have port Out_Last  output  1  asserted with the final symbol of a bank.
REQ-015 SHALL have port Bank_Free  output  1  one-cycle pulse when a bank has been fully streamed.
REQ-016 SHALL have port Overrun  output  1  sticky error flag.
REQ-017 SHALL have port Busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 SHALL track fill_bank (toggle on each accepted Done_In), rd_bank, pending count (0..2), and a stored length per bank.
REQ-019 SHALL, on Done_In with Last_addr_In=0, drop the frame: no toggle, no pending change.
REQ-020 SHALL clamp a stored length greater than MAX_SYMB to MAX_SYMB.
REQ-021 SHALL, on Done_In while pending=2, set Overrun, drop the frame, and leave the stored lengths untouched.
REQ-022 SHALL leave pending unchanged when Done_In and Bank_Free coincide; both events take effect.
REQ-023 SHALL implement FSM IDLE->READ when pending>0 (latch len, Rd_addr=0); READ->DRAIN after issuing the read at address len-1; DRAIN->IDLE once the last symbol is accepted.
REQ-024 SHALL, on the DRAIN->IDLE transition, pulse Bank_Free, toggle rd_bank, and decrement pending.
REQ-025 SHALL issue Rd_en only in READ, and only when (FIFO occupancy + in-flight reads) < 2; Rd_addr increments by 1 per issued read.
REQ-026 SHALL capture returned data into a 2-entry FIFO; Out_* is the FIFO head; Out_Valid = FIFO not empty.
REQ-027 SHALL hold Out_I, Out_Q, and Out_Last stable while Out_Valid=1 and Out_Ready=0.
REQ-028 SHALL sustain 1 symbol/cycle with Out_Ready held high; first Out_Valid occurs 3 cycles after Done_In (IDLE->READ 1, read 1, FIFO write 1).
REQ-029 SHALL start the next pending bank in the cycle after returning to IDLE; no symbol of one bank interleaves with another.
REQ-030 SHALL pass data bit-exact (no scaling or sign change).

Reset
REQ-031 SHALL, while RST_Mod=0, force: state IDLE, pending 0, fill_bank 0, rd_bank 0, lengths 0, FIFO empty, Rd_en 0, Rd_addr 0, Out_I/Out_Q 0, Out_Valid 0, Out_Last 0, Bank_Free 0, Overrun 0, Busy 0.
REQ-032 SHALL, on reset assertion mid-frame, discard the frame; after release, the block waits for a new Done_In.

Structure
REQ-033 SHALL place DATA_WIDTH, ADDR_WIDTH, MAX_SYMB defaults and the FSM state enum (IDLE, READ, DRAIN) in the shared PUSCH package.
REQ-034 SHALL implement the 2-entry FIFO as sub-module sym_skid_fifo; the FSM and bank tracking reside in mod_buffer_reader.

Verification
REQ-035 SHALL cover: Done_In with Last_addr_In=4, Out_Ready=1 -> 4 symbols from bank 0 at addrs 0..3 on consecutive cycles, Out_Last on the 4th, then Bank_Free.
REQ-036 SHALL cover: length 8, Out_Ready toggled 1010... -> 8 symbols in order, held stable while stalled, none lost or duplicated.
REQ-037 SHALL cover: two Done_In pulses (lengths 5, 3) back-to-back -> bank 0 (5 symbols) then bank 1 (3 symbols), two Bank_Free pulses, Overrun=0.
REQ-038 SHALL cover: third Done_In while pending=2 -> Overrun=1 and stays 1; first two banks still stream correctly.
REQ-039 SHALL cover: Last_addr_In=2047 -> exactly 1200 symbols are read; Last_addr_In=0 -> no activity.
REQ-040 SHALL cover: RST_Mod low at symbol 10 of 1200 -> all outputs at reset values; a new Done_In (length 2) then streams from bank 0.

Source files
------------

// File: rtl/mod_buffer_reader_pkg.sv
// Shared parameters and FSM state type for the PUSCH modulation buffer reader.
package mod_buffer_reader_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 18;
    localparam int unsigned DEF_ADDR_WIDTH = 11;
    localparam int unsigned DEF_MAX_SYMB   = 1200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sym_skid_fifo.sv
// Two-entry symbol FIFO; the head stays put until it is popped.
module sym_skid_fifo #(
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             pop_ok;
    logic             push_ok;

    // Qualify requests so the FIFO never over- or under-flows
    always_comb begin
        pop_ok  = pop_i && (count_q != 2'd0);
        push_ok = push_i && ((count_q != 2'd2) || pop_ok);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/mod_buffer_reader.sv
// Streams completed ping-pong buffer banks out as I/Q symbols with backpressure.
module mod_buffer_reader
    import mod_buffer_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MAX_SYMB   = DEF_MAX_SYMB
) (
    input  logic                  CLK_Mod,
    input  logic                  RST_Mod,
    input  logic                  Done_In,
    input  logic [ADDR_WIDTH-1:0] Last_addr_In,
    output logic                  Rd_en,
    output logic                  Rd_bank,
    output logic [ADDR_WIDTH-1:0] Rd_addr,
    input  logic [DATA_WIDTH-1:0] Rd_data_I,
    input  logic [DATA_WIDTH-1:0] Rd_data_Q,
    output logic [DATA_WIDTH-1:0] Out_I,
    output logic [DATA_WIDTH-1:0] Out_Q,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  Out_Last,
    output logic                  Bank_Free,
    output logic                  Overrun,
    output logic                  Busy
);

    localparam int unsigned           FIFO_W  = 2 * DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(MAX_SYMB);

    rd_state_e             state_q, state_d;
    logic [1:0]            pending_q, pending_d;
    logic                  fill_bank_q, fill_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] len_q [2];
    logic [ADDR_WIDTH-1:0] len_d [2];
    logic [ADDR_WIDTH-1:0] cur_len_q, cur_len_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  inflight_q, inflight_last_q;
    logic                  overrun_q, overrun_d;
    logic                  bank_free_q;

    logic                  done_acc_c;
    logic                  free_c;
    logic                  rd_en_c;
    logic                  rd_last_c;
    logic                  pop_c;
    logic [2:0]            occ_c;
    logic [ADDR_WIDTH-1:0] clamp_len_c;

    logic [FIFO_W-1:0]     fifo_head;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;

    // Writer-side bookkeeping: accept, drop or flag each Done_In
    always_comb begin
        done_acc_c  = 1'b0;
        fill_bank_d = fill_bank_q;
        overrun_d   = overrun_q;
        len_d       = len_q;
        clamp_len_c = (Last_addr_In > MAX_LEN) ? MAX_LEN : Last_addr_In;
        if (Done_In && (Last_addr_In != '0)) begin
            if (pending_q == 2'd2) begin
                overrun_d = 1'b1;
            end else begin
                done_acc_c         = 1'b1;
                fill_bank_d        = ~fill_bank_q;
                len_d[fill_bank_q] = clamp_len_c;
            end
        end
    end

    // Read FSM; Rd_en is combinational because the credit check must see this cycle's pop
    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        rd_addr_d = rd_addr_q;
        rd_en_c   = 1'b0;
        rd_last_c = 1'b0;
        free_c    = 1'b0;
        pop_c     = fifo_valid && Out_Ready;
        occ_c     = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);
        unique case (state_q)
            IDLE: begin
                if ((pending_q != 2'd0) || done_acc_c) begin
                    state_d   = READ;
                    cur_len_d = len_d[rd_bank_q];
                    rd_addr_d = '0;
                end
            end
            READ: begin
                if (occ_c < 3'd2) begin
                    rd_en_c   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    if (rd_addr_q == (cur_len_q - ADDR_WIDTH'(1))) begin
                        rd_last_c = 1'b1;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_c && fifo_head[FIFO_W-1]) begin
                    free_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_bank_d = free_c ? ~rd_bank_q : rd_bank_q;
        case ({done_acc_c, free_c})
            2'b10:   pending_d = pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
        if (!RST_Mod) begin
            state_q         <= IDLE;
            pending_q       <= 2'd0;
            fill_bank_q     <= 1'b0;
            rd_bank_q       <= 1'b0;
            len_q[0]        <= '0;
            len_q[1]        <= '0;
            cur_len_q       <= '0;
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            overrun_q       <= 1'b0;
            bank_free_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            fill_bank_q     <= fill_bank_d;
            rd_bank_q       <= rd_bank_d;
            len_q[0]        <= len_d[0];
            len_q[1]        <= len_d[1];
            cur_len_q       <= cur_len_d;
            rd_addr_q       <= rd_addr_d;
            inflight_q      <= rd_en_c;
            inflight_last_q <= rd_last_c;
            overrun_q       <= overrun_d;
            bank_free_q     <= free_c;
        end
    end

    sym_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk_i   (CLK_Mod),
        .rst_ni  (RST_Mod),
        .push_i  (inflight_q),
        .data_i  ({inflight_last_q, Rd_data_I, Rd_data_Q}),
        .pop_i   (pop_c),
        .data_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign Rd_en                   = rd_en_c;
    assign Rd_bank                 = rd_bank_q;
    assign Rd_addr                 = rd_addr_q;
    assign {Out_Last, Out_I, Out_Q} = fifo_head;
    assign Out_Valid               = fifo_valid;
    assign Bank_Free               = bank_free_q;
    assign Overrun                 = overrun_q;
    assign Busy                    = (state_q != IDLE);

endmodule
